isp_pattern_gen: RTL and testbench

- AXI4-Stream video source (transmitter) for the ISP chain.
- Emits 4 pixels/beat RGB888 on a 96-bit bus, in the same beat format the ISP stages consume: pixel k at tdata[24k+:24], R[23:16] G[15:8] B[7:0]; tuser = start of frame, tlast = end of line.
- Drives the saturation/colour stages in place of the sensor path for bring-up and regression.

---
 rtl/isp_patgen_pkg.sv | 31 +++
 rtl/isp_patgen_pixel.sv | 43 ++++
 rtl/isp_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_isp_pattern_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_patgen_pkg.sv
// Shared types and constants for the ISP test-pattern source: pattern codes,
// FSM states, colour-bar table and the 4-pixel beat packer.
package isp_patgen_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam int X_W = 16;
  localparam int Y_W = 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACTIVE    = 2'd1,
    S_LINE_GAP  = 2'd2,
    S_FRAME_GAP = 2'd3
  } state_t;

  // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [95:0] pack4(input logic [23:0] p0, input logic [23:0] p1,
                                        input logic [23:0] p2, input logic [23:0] p3);
    return {p3, p2, p1, p0};
  endfunction

endpackage

// File: rtl/isp_patgen_pixel.sv
// Combinational colour of one pixel for the selected test pattern.
// With ISP_PATGEN_MOTION_EN defined, ramp and checker scroll by frame_cnt.
module isp_patgen_pixel
  import isp_patgen_pkg::*;
#(
  parameter int          H_ACTIVE  = 1920,
  parameter logic [23:0] SOLID_RGB = 24'h808080
) (
  input  logic [1:0]     sel,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [7:0]     frame_cnt,
  output logic [23:0]    rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;
  logic [7:0] xm;
  logic       unused_bits;

  assign bar = 3'(x / X_W'(BAR_W));

`ifdef ISP_PATGEN_MOTION_EN
  assign xm = x[7:0] + frame_cnt;
`else
  assign xm = x[7:0];
`endif

  // Only y[4] feeds the checker; the rest of y (and frame_cnt when static) is don't-care.
  assign unused_bits = ^{y, frame_cnt};

  always_comb begin
    rgb = 24'h000000;
    case (sel)
      PAT_BARS:  rgb = BAR_RGB[bar];
      PAT_RAMP:  rgb = {xm, xm, xm};
      PAT_SOLID: rgb = SOLID_RGB;
      default:   rgb = (xm[4] ^ y[4]) ? 24'hFFFFFF : 24'h000000;
    endcase
  end

endmodule

// File: rtl/isp_pattern_gen.sv
// AXI4-Stream test-pattern source: 4 RGB888 pixels per beat, tuser = SOF, tlast = EOL.
// Optional macro ISP_PATGEN_MOTION_EN makes ramp/checker scroll one pixel per frame.
module isp_pattern_gen
  import isp_patgen_pkg::*;
#(
  parameter int          H_ACTIVE  = 1920,
  parameter int          V_ACTIVE  = 1080,
  parameter int          LINE_GAP  = 8,
  parameter int          FRAME_GAP = 64,
  parameter logic [23:0] SOLID_RGB = 24'h808080
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_enable,
  input  logic [1:0]  I_pattern_sel,
  output logic [95:0] O_tdata,
  output logic        O_tvalid,
  output logic        O_tuser,
  output logic        O_tlast,
  input  logic        O_tready,
  output logic        O_busy
);

  localparam int BEATS   = H_ACTIVE / 4;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int GAP_MAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

  state_t              state, nxt_state;
  logic [BEAT_W-1:0]   beat_cnt, nxt_beat;
  logic [LINE_W-1:0]   line_cnt, nxt_line;
  logic [GAP_W-1:0]    gap_cnt, nxt_gap;
  logic [7:0]          frame_cnt, nxt_frame;
  logic [1:0]          sel_q, nxt_sel;
  logic                nxt_tvalid;
  logic                load;
  logic                last_beat, last_line;
  logic                nxt_tuser, nxt_tlast;
  logic [X_W-1:0]      lane_x   [4];
  logic [23:0]         lane_rgb [4];

  assign last_beat = (int'(beat_cnt) == BEATS - 1);
  assign last_line = (int'(line_cnt) == V_ACTIVE - 1);

  // Counters always point at the beat being presented (or about to be presented
  // after a gap), so the pixel lanes below compute the next output from nxt_*.
  always_comb begin
    nxt_state  = state;
    nxt_beat   = beat_cnt;
    nxt_line   = line_cnt;
    nxt_gap    = gap_cnt;
    nxt_frame  = frame_cnt;
    nxt_sel    = sel_q;
    nxt_tvalid = O_tvalid;
    load       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (I_enable) begin
          nxt_sel    = I_pattern_sel;
          nxt_beat   = '0;
          nxt_line   = '0;
          nxt_tvalid = 1'b1;
          load       = 1'b1;
          nxt_state  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (O_tvalid && O_tready) begin
          if (!last_beat) begin
            nxt_beat = beat_cnt + BEAT_W'(1);
            load     = 1'b1;
          end else if (!last_line) begin
            nxt_beat = '0;
            nxt_line = line_cnt + LINE_W'(1);
            if (LINE_GAP == 0) begin
              load = 1'b1;
            end else begin
              nxt_state  = S_LINE_GAP;
              nxt_gap    = '0;
              nxt_tvalid = 1'b0;
            end
          end else begin
            nxt_frame = frame_cnt + 8'd1;
            nxt_beat  = '0;
            nxt_line  = '0;
            if (FRAME_GAP != 0) begin
              nxt_state  = S_FRAME_GAP;
              nxt_gap    = '0;
              nxt_tvalid = 1'b0;
            end else if (I_enable) begin
              nxt_sel = I_pattern_sel;
              load    = 1'b1;
            end else begin
              nxt_state  = S_IDLE;
              nxt_tvalid = 1'b0;
            end
          end
        end
      end
      S_LINE_GAP: begin
        if (int'(gap_cnt) + 1 >= LINE_GAP) begin
          nxt_state  = S_ACTIVE;
          nxt_tvalid = 1'b1;
          load       = 1'b1;
        end else begin
          nxt_gap = gap_cnt + GAP_W'(1);
        end
      end
      S_FRAME_GAP: begin
        if (int'(gap_cnt) + 1 >= FRAME_GAP) begin
          if (I_enable) begin
            nxt_sel    = I_pattern_sel;
            nxt_state  = S_ACTIVE;
            nxt_tvalid = 1'b1;
            load       = 1'b1;
          end else begin
            nxt_state = S_IDLE;
          end
        end else begin
          nxt_gap = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        nxt_state  = S_IDLE;
        nxt_tvalid = 1'b0;
      end
    endcase
  end

  assign nxt_tuser = (nxt_beat == '0) && (nxt_line == '0);
  assign nxt_tlast = (int'(nxt_beat) == BEATS - 1);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    assign lane_x[k] = X_W'({nxt_beat, LANE});
    isp_patgen_pixel #(
      .H_ACTIVE  (H_ACTIVE),
      .SOLID_RGB (SOLID_RGB)
    ) u_pixel (
      .sel       (nxt_sel),
      .x         (lane_x[k]),
      .y         (Y_W'(nxt_line)),
      .frame_cnt (nxt_frame),
      .rgb       (lane_rgb[k])
    );
  end

  // Output stage: data/sideband only change when a new beat is loaded,
  // which keeps them stable across tready stalls.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      line_cnt  <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      sel_q     <= '0;
      O_tdata   <= '0;
      O_tvalid  <= 1'b0;
      O_tuser   <= 1'b0;
      O_tlast   <= 1'b0;
      O_busy    <= 1'b0;
    end else begin
      state     <= nxt_state;
      beat_cnt  <= nxt_beat;
      line_cnt  <= nxt_line;
      gap_cnt   <= nxt_gap;
      frame_cnt <= nxt_frame;
      sel_q     <= nxt_sel;
      O_tvalid  <= nxt_tvalid;
      O_busy    <= (nxt_state != S_IDLE);
      if (load) begin
        O_tdata <= pack4(lane_rgb[0], lane_rgb[1], lane_rgb[2], lane_rgb[3]);
        O_tuser <= nxt_tuser;
        O_tlast <= nxt_tlast;
      end else if (!nxt_tvalid) begin
        O_tuser <= 1'b0;
        O_tlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_isp_pattern_gen.sv
// Self-checking bench for isp_pattern_gen: spot-vector table, reference model,
// stall stability, enable/reset corner cases and a zero-gap instance.
module tb_isp_pattern_gen;

  localparam int H   = 32;
  localparam int V   = 4;
  localparam int LG  = 2;
  localparam int FG  = 4;
  localparam int BPL = H / 4;
`ifdef ISP_PATGEN_MOTION_EN
  localparam bit MOTION = 1'b1;
`else
  localparam bit MOTION = 1'b0;
`endif

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        rst_n, enable, tready;
  logic [1:0]  sel;
  logic [95:0] tdata;
  logic        tvalid, tuser, tlast, busy;
  logic        enable1, tready1;
  logic [1:0]  sel1;
  logic [95:0] d1_tdata;
  logic        d1_tvalid, d1_tuser, d1_tlast, d1_busy;

  always #5 clk = ~clk;

  isp_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(LG), .FRAME_GAP(FG),
                    .SOLID_RGB(24'h808080)) u_dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_enable(enable), .I_pattern_sel(sel),
    .O_tdata(tdata), .O_tvalid(tvalid), .O_tuser(tuser), .O_tlast(tlast),
    .O_tready(tready), .O_busy(busy));

  isp_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(1), .LINE_GAP(0), .FRAME_GAP(0),
                    .SOLID_RGB(24'h808080)) u_dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_enable(enable1), .I_pattern_sel(sel1),
    .O_tdata(d1_tdata), .O_tvalid(d1_tvalid), .O_tuser(d1_tuser), .O_tlast(d1_tlast),
    .O_tready(tready1), .O_busy(d1_busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model, written directly from the pattern rules.
  function automatic logic [23:0] exp_pix(input int s, input int x, input int y, input int f);
    int xm;
    logic [7:0] v;
    xm = x + (MOTION ? f : 0);
    case (s)
      0: return BARS[x / (H / 8)];
      1: begin v = 8'(xm % 256); return {v, v, v}; end
      2: return 24'h808080;
      default: return ((((xm / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  function automatic logic [97:0] exp_beat(input int s, input int b, input int l, input int f);
    logic [95:0] d;
    for (int k = 0; k < 4; k++) d[24*k +: 24] = exp_pix(s, 4*b + k, l, f);
    return {(b == 0 && l == 0), (b == BPL - 1), d};
  endfunction

  typedef struct {
    int          s;
    int          b;
    int          l;
    logic [97:0] exp;
  } vec_t;

  function automatic vec_t mk(input int s, input int b, input int l, input logic u,
                              input logic t, input logic [95:0] d);
    vec_t v;
    v.s = s; v.b = b; v.l = l; v.exp = {u, t, d};
    return v;
  endfunction

  vec_t vecs [11];

  // Bench model state
  int          m_beat, m_line, m_frame, m_sel;
  int          beats, tusers;
  bit          rand_ready, stall, in_gap;
  logic [97:0] held;
  int          gap_len;
  int          gaps[$];
  logic [97:0] rx [V*BPL];

  task automatic step();
    logic [97:0] cur;
    bit rdy;
    @(negedge clk);
    cur = {tuser, tlast, tdata};
    if (stall) begin
      chk("stall_valid", 128'(tvalid), 128'(1));
      chk("stall_hold", 128'(cur), 128'(held));
    end
    if (in_gap) begin
      if (tvalid || !busy) begin gaps.push_back(gap_len); in_gap = 1'b0; end
      else gap_len++;
    end
    rdy = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
    tready = rdy;
    if (tvalid && rdy) begin
      chk($sformatf("beat_l%0d_b%0d", m_line, m_beat), 128'(cur),
          128'(exp_beat(m_sel, m_beat, m_line, m_frame)));
      rx[m_line*BPL + m_beat] = cur;
      beats++;
      if (tuser) tusers++;
      if (tlast) begin in_gap = 1'b1; gap_len = 0; end
      m_beat++;
      if (m_beat == BPL) begin
        m_beat = 0; m_line++;
        if (m_line == V) begin m_line = 0; m_frame = (m_frame + 1) % 256; end
      end
    end
    stall = tvalid && !rdy;
    held  = cur;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1 chk("rst_outputs", 128'({busy, tvalid, tuser, tlast, tdata}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_beat = 0; m_line = 0; m_frame = 0;
    beats = 0; tusers = 0; stall = 1'b0; in_gap = 1'b0; gaps.delete();
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((busy || tvalid) && n < max) begin step(); n++; end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL timeout_idle: still busy after %0d cycles", n);
    end
  endtask

  task automatic run_beats(input int target, input int max);
    int n = 0;
    while (beats < target && n < max) begin step(); n++; end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL timeout_beats: got %0d beats, required %0d", beats, target);
    end
  endtask

  task automatic run_to(input int l, input int b, input int max);
    int n = 0;
    while (!(m_line == l && m_beat == b) && n < max) begin step(); n++; end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL timeout_pos: at line %0d beat %0d, required line %0d beat %0d",
               m_line, m_beat, l, b);
    end
  endtask

  task automatic run_dut1();
    int b = 0, frames = 0, nbeats = 0, holes = 0;
    bit started = 1'b0, done = 1'b0;
    @(negedge clk);
    sel1 = 2'd1; enable1 = 1'b1;
    for (int c = 0; c < 2400 && !done; c++) begin
      @(negedge clk);
      if (d1_tvalid) begin
        started = 1'b1;
        chk($sformatf("d1_f%0d_b%0d", frames, b), 128'({d1_tuser, d1_tlast, d1_tdata}),
            128'(exp_beat(1, b, 0, frames % 256)));
        nbeats++; b++;
        if (b == BPL) begin b = 0; frames++; end
        if (frames == 257 && b == 1) enable1 = 1'b0;
      end else if (started && d1_busy) begin
        holes++;
      end
      if (started && !d1_busy) done = 1'b1;
    end
    chk("d1_frames", 128'(frames), 128'(258));
    chk("d1_beats", 128'(nbeats), 128'(258 * BPL));
    chk("d1_holes", 128'(holes), 128'(0));
    chk("d1_idle", 128'({d1_busy, d1_tvalid}), 128'(0));
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 1'b1, 1'b0, {4{24'hFFFFFF}});
    vecs[1]  = mk(0, 5, 0, 1'b0, 1'b0, {4{24'hFF0000}});
    vecs[2]  = mk(0, 7, 0, 1'b0, 1'b1, {4{24'h000000}});
    vecs[3]  = mk(0, 2, 3, 1'b0, 1'b0, {4{24'h00FFFF}});
    vecs[4]  = mk(1, 1, 0, 1'b0, 1'b0, 96'h070707_060606_050505_040404);
    vecs[5]  = mk(1, 1, 3, 1'b0, 1'b0, 96'h070707_060606_050505_040404);
    vecs[6]  = mk(1, 7, 2, 1'b0, 1'b1, 96'h1F1F1F_1E1E1E_1D1D1D_1C1C1C);
    vecs[7]  = mk(2, 3, 1, 1'b0, 1'b0, {4{24'h808080}});
    vecs[8]  = mk(3, 4, 0, 1'b0, 1'b0, {4{24'hFFFFFF}});
    vecs[9]  = mk(3, 3, 2, 1'b0, 1'b0, {4{24'h000000}});
    vecs[10] = mk(3, 0, 0, 1'b1, 1'b0, {4{24'h000000}});

    rst_n = 1'b0; enable = 1'b0; sel = 2'd0; tready = 1'b1;
    enable1 = 1'b0; sel1 = 2'd0; tready1 = 1'b1;
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_d1_outputs", 128'({d1_busy, d1_tvalid, d1_tuser, d1_tlast, d1_tdata}), 128'(0));

    // One enable pulse per pattern; a mid-frame sel change must be ignored.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      m_sel = s; sel = 2'(s); enable = 1'b1;
      step();
      enable = 1'b0; sel = 2'(s ^ 1);
      run_until_idle(500);
      chk($sformatf("p%0d_beats", s), 128'(beats), 128'(V * BPL));
      chk($sformatf("p%0d_tusers", s), 128'(tusers), 128'(1));
      chk($sformatf("p%0d_ngaps", s), 128'(gaps.size()), 128'(4));
      for (int i = 0; i < gaps.size() && i < 4; i++)
        chk($sformatf("p%0d_gap%0d", s, i), 128'(gaps[i]), 128'((i == 3) ? FG : LG));
      chk($sformatf("p%0d_idle_busy", s), 128'(busy), 128'(0));
      for (int i = 0; i < 11; i++)
        if (vecs[i].s == s)
          chk($sformatf("vec%0d", i), 128'(rx[vecs[i].l*BPL + vecs[i].b]), 128'(vecs[i].exp));
    end

    // Random backpressure
    do_reset();
    m_sel = 0; sel = 2'd0; rand_ready = 1'b1; enable = 1'b1;
    step();
    enable = 1'b0;
    run_until_idle(2000);
    rand_ready = 1'b0; tready = 1'b1;
    chk("rr_beats", 128'(beats), 128'(V * BPL));
    chk("rr_tusers", 128'(tusers), 128'(1));

    // Enable dropped mid-frame: frame completes, no second frame
    do_reset();
    m_sel = 0; sel = 2'd0; enable = 1'b1;
    run_to(1, 3, 200);
    enable = 1'b0;
    run_until_idle(500);
    chk("drop_beats", 128'(beats), 128'(V * BPL));
    chk("drop_tusers", 128'(tusers), 128'(1));

    // Enable held for two frames (checker, scrolls when motion is built in)
    do_reset();
    m_sel = 3; sel = 2'd3; enable = 1'b1;
    run_beats(V * BPL + 8, 400);
    enable = 1'b0;
    run_until_idle(500);
    chk("hold_beats", 128'(beats), 128'(2 * V * BPL));
    chk("hold_tusers", 128'(tusers), 128'(2));
    chk("hold_ngaps", 128'(gaps.size()), 128'(8));
    if (gaps.size() > 3) chk("hold_frame_gap", 128'(gaps[3]), 128'(FG));
    chk("hold_f1_l3b3_lane3", 128'(rx[3*BPL + 3][95:72]),
        128'(MOTION ? 24'hFFFFFF : 24'h000000));

    // Asynchronous reset in the middle of line 2
    do_reset();
    m_sel = 0; sel = 2'd0; enable = 1'b1;
    run_to(2, 2, 200);
    do_reset();
    run_beats(1, 20);
    chk("rst_restart_first", 128'(rx[0][97:96]), 128'(2'b10));
    run_beats(9, 50);
    enable = 1'b0;
    run_until_idle(500);
    chk("rst_restart_beats", 128'(beats), 128'(V * BPL));
    chk("rst_restart_tusers", 128'(tusers), 128'(1));

    // Zero-gap, single-line instance through a frame counter wrap
    run_dut1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
